// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access sequencer.
//   WORD_SIZE   - address/data width of the CPU memory port
//   mau_state_e - sequencer state encoding
//   TimeoutFill - word written to the destination register on a read timeout
package mem_access_pkg;

  localparam int unsigned WORD_SIZE = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdWait = 2'd1,
    StWrWait = 2'd2
  } mau_state_e;

  localparam logic [15:0] TimeoutFill = 16'hFFFF;

endpackage

// File: rtl/mau_wait_counter.sv
// Wait-cycle counter for the memory access sequencer timeout.
//   clk, reset  - clock and synchronous active-high reset
//   clear       - restart the count from zero (takes priority over enable)
//   enable      - count one wait cycle
//   count_done  - current count equals Terminal
module mau_wait_counter
  import mem_access_pkg::*;
#(
  parameter int unsigned      Width    = 8,
  parameter logic [Width-1:0] Terminal = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic count_done
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_done = (count_q == Terminal);

endmodule

// File: rtl/mem_access_unit.sv
// Memory access sequencer between the multicycle control unit and the external memory port.
// Turns level-held mem_read/mem_write requests into exactly one memory transaction each,
// captures read data into ir or mdr and reports completion with a one-cycle mem_done pulse.
//
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   mem_read, mem_write  - level requests from the control unit (read wins if both)
//   i_or_d               - address/destination select: 0 = pc/ir, 1 = alu_out/mdr
//   pc, alu_out, wdata   - address sources and store data
//   readM, writeM        - external strobes
//   address, mem_wdata   - latched transaction address and store data
//   mem_rdata            - external read data
//   input_ready          - read data valid
//   ack_output           - write completed
//   ir, mdr              - captured instruction / data word
//   mem_done             - one-cycle completion pulse
//   busy                 - transaction outstanding
//   mem_err              - one-cycle timeout pulse
//
// Build option: define MAU_TIMEOUT_EN to abort a wait after TIMEOUT cycles without handshake.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned WORD_SIZE = mem_access_pkg::WORD_SIZE,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 i_or_d,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic [WORD_SIZE-1:0] alu_out,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 input_ready,
  input  logic                 ack_output,
  output logic [WORD_SIZE-1:0] ir,
  output logic [WORD_SIZE-1:0] mdr,
  output logic                 mem_done,
  output logic                 busy,
  output logic                 mem_err
);

  mau_state_e state;
  logic       served;  // current request level already serviced
  logic       dest;    // read destination: 0 = ir, 1 = mdr
  logic       accept;

  assign accept = (state == StIdle) && !served && (mem_read || mem_write);
  assign busy   = (state != StIdle);

`ifdef MAU_TIMEOUT_EN
  logic wait_tc;
  logic mem_err_q;

  mau_wait_counter #(
    .Width   (8),
    .Terminal(8'(TIMEOUT - 1))
  ) u_wait_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .enable    (busy),
    .count_done(wait_tc)
  );

  assign mem_err = mem_err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign mem_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      served    <= 1'b0;
      dest      <= 1'b0;
      readM     <= 1'b0;
      writeM    <= 1'b0;
      address   <= '0;
      mem_wdata <= '0;
      ir        <= '0;
      mdr       <= '0;
      mem_done  <= 1'b0;
`ifdef MAU_TIMEOUT_EN
      mem_err_q <= 1'b0;
`endif
    end else begin
      mem_done <= 1'b0;
`ifdef MAU_TIMEOUT_EN
      mem_err_q <= 1'b0;
`endif
      // Request level dropped: the next assertion is a fresh request.
      // A completion later in this block overrides this.
      if (!mem_read && !mem_write) begin
        served <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (accept) begin
            address <= i_or_d ? alu_out : pc;
            if (mem_read) begin
              dest  <= i_or_d;
              readM <= 1'b1;
              state <= StRdWait;
            end else begin
              mem_wdata <= wdata;
              writeM    <= 1'b1;
              state     <= StWrWait;
            end
          end
        end

        StRdWait: begin
          if (input_ready) begin
            if (dest) begin
              mdr <= mem_rdata;
            end else begin
              ir <= mem_rdata;
            end
            readM    <= 1'b0;
            mem_done <= 1'b1;
            served   <= 1'b1;
            state    <= StIdle;
          end
`ifdef MAU_TIMEOUT_EN
          else if (wait_tc) begin
            if (dest) begin
              mdr <= WORD_SIZE'(TimeoutFill);
            end else begin
              ir <= WORD_SIZE'(TimeoutFill);
            end
            readM     <= 1'b0;
            mem_done  <= 1'b1;
            mem_err_q <= 1'b1;
            served    <= 1'b1;
            state     <= StIdle;
          end
`endif
        end

        StWrWait: begin
          if (ack_output) begin
            writeM   <= 1'b0;
            mem_done <= 1'b1;
            served   <= 1'b1;
            state    <= StIdle;
          end
`ifdef MAU_TIMEOUT_EN
          else if (wait_tc) begin
            writeM    <= 1'b0;
            mem_done  <= 1'b1;
            mem_err_q <= 1'b1;
            served    <= 1'b1;
            state     <= StIdle;
          end
`endif
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by randomized
// transactions, checked against a transaction-level model of ir/mdr and strobe episodes.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        i_or_d = 1'b0;
  logic [15:0] pc = '0;
  logic [15:0] alu_out = '0;
  logic [15:0] wdata = '0;
  logic        readM;
  logic        writeM;
  logic [15:0] address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        input_ready = 1'b0;
  logic        ack_output = 1'b0;
  logic [15:0] ir;
  logic [15:0] mdr;
  logic        mem_done;
  logic        busy;
  logic        mem_err;

  int vectors = 0;
  int miscompares = 0;

  // Observed activity, sampled on the falling edge.
  int rd_cyc = 0;
  int wr_cyc = 0;
  int done_cnt = 0;

  // Reference model state.
  logic [15:0] exp_ir = '0;
  logic [15:0] exp_mdr = '0;

  mem_access_unit #(
    .WORD_SIZE(16),
    .TIMEOUT  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .pc         (pc),
    .alu_out    (alu_out),
    .wdata      (wdata),
    .readM      (readM),
    .writeM     (writeM),
    .address    (address),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .input_ready(input_ready),
    .ack_output (ack_output),
    .ir         (ir),
    .mdr        (mdr),
    .mem_done   (mem_done),
    .busy       (busy),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      rd_cyc   <= rd_cyc + int'(readM);
      wr_cyc   <= wr_cyc + int'(writeM);
      done_cnt <= done_cnt + int'(mem_done);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction. lat = wait cycles before the handshake, extra = cycles the
  // request stays held after completion, drop = release the request right after acceptance,
  // both = raise mem_write alongside a read, early = handshake asserted with the request.
  task automatic txn(input bit is_wr, input bit sel, input bit both, input bit drop,
                     input bit early, input int lat, input int extra,
                     input logic [15:0] pcv, input logic [15:0] aluv,
                     input logic [15:0] wd, input logic [15:0] rd);
    logic [15:0] exp_addr;
    int rd0, wr0, dn0;
    exp_addr = sel ? aluv : pcv;
    rd0 = rd_cyc;
    wr0 = wr_cyc;
    dn0 = done_cnt;
    pc = pcv;
    alu_out = aluv;
    wdata = wd;
    i_or_d = sel;
    mem_read = !is_wr;
    mem_write = is_wr | both;
    if (early) begin
      input_ready = 1'b1;
      ack_output = 1'b1;
    end
    step();
    input_ready = 1'b0;
    ack_output = 1'b0;
    if (drop) begin
      mem_read = 1'b0;
      mem_write = 1'b0;
    end
    check("strobe_up", is_wr ? writeM : readM, 1);
    check("other_strobe", is_wr ? readM : writeM, 0);
    check("address", address, exp_addr);
    if (is_wr) check("mem_wdata", mem_wdata, wd);
    check("busy_up", busy, 1);
    repeat (lat) begin
      step();
      check("waiting", {is_wr ? writeM : readM, mem_done, busy}, 3'b101);
    end
    if (is_wr) begin
      ack_output = 1'b1;
    end else begin
      input_ready = 1'b1;
      mem_rdata = rd;
    end
    step();
    ack_output = 1'b0;
    input_ready = 1'b0;
    mem_rdata = 16'($urandom);
    if (!is_wr) begin
      if (sel) exp_mdr = rd;
      else exp_ir = rd;
    end
    check("done_pulse", {mem_done, readM, writeM, busy, mem_err}, 5'b10000);
    check("ir", ir, exp_ir);
    check("mdr", mdr, exp_mdr);
    repeat (extra + 1) begin
      step();
      check("no_reissue", {mem_done, readM, writeM, busy}, 4'b0000);
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    step();
    check("strobe_cycles", is_wr ? wr_cyc - wr0 : rd_cyc - rd0, lat + 1);
    check("other_cycles", is_wr ? rd_cyc - rd0 : wr_cyc - wr0, 0);
    check("done_count", done_cnt - dn0, 1);
  endtask

  initial begin
    int dn0;
    // Reset state.
    step();
    step();
    check("rst_strobes", {readM, writeM, mem_done, busy, mem_err}, 5'b00000);
    check("rst_address", address, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    check("rst_ir", ir, 16'h0000);
    check("rst_mdr", mdr, 16'h0000);
    reset = 1'b0;
    step();

    // Fetch, load, store.
    txn(0, 0, 0, 0, 0, 2, 0, 16'h0010, 16'h0000, 16'h0000, 16'hA123);
    txn(0, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0042, 16'h0000, 16'h5555);
    txn(1, 1, 0, 0, 0, 1, 0, 16'h0000, 16'h0080, 16'hBEEF, 16'h0000);

    // Held request: one transaction, then a fresh assertion gives a second.
    txn(0, 0, 0, 0, 0, 0, 4, 16'h0100, 16'h0000, 16'h0000, 16'h1357);
    txn(0, 0, 0, 0, 0, 0, 0, 16'h0101, 16'h0000, 16'h0000, 16'h2468);

    // Both requests high: read only; then the write on its own fresh assertion.
    txn(0, 1, 1, 0, 0, 1, 2, 16'h0000, 16'h0200, 16'h7777, 16'h0F0F);
    txn(1, 0, 0, 0, 0, 0, 0, 16'h0300, 16'h0000, 16'h4242, 16'h0000);

    // Handshake in the request cycle is ignored; request dropped mid-transaction completes.
    txn(0, 0, 0, 1, 1, 1, 0, 16'h0400, 16'h0000, 16'h0000, 16'hC0DE);
    txn(1, 1, 0, 1, 1, 2, 0, 16'h0000, 16'h0500, 16'hFACE, 16'h0000);

    // Reset during a read wait.
    i_or_d = 1'b0;
    pc = 16'h1234;
    mem_read = 1'b1;
    step();
    mem_read = 1'b0;
    check("rst_mid_accept", readM, 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_ir = '0;
    exp_mdr = '0;
    check("rst_mid_outputs", {readM, writeM, busy, mem_done}, 4'b0000);
    check("rst_mid_ir", ir, exp_ir);
    check("rst_mid_mdr", mdr, exp_mdr);
    dn0 = done_cnt;
    input_ready = 1'b1;
    repeat (3) step();
    input_ready = 1'b0;
    check("rst_mid_no_done", done_cnt - dn0, 0);
    check("rst_mid_idle", {readM, busy}, 2'b00);
    txn(0, 0, 0, 0, 0, 1, 0, 16'h1235, 16'h0000, 16'h0000, 16'h9ABC);

`ifdef MAU_TIMEOUT_EN
    // Read timeout after 4 wait cycles fills ir.
    i_or_d = 1'b0;
    pc = 16'h0600;
    mem_read = 1'b1;
    step();
    check("to_accept", readM, 1);
    repeat (3) begin
      step();
      check("to_waiting", {readM, mem_err, mem_done}, 3'b100);
    end
    step();
    exp_ir = 16'hFFFF;
    check("to_pulse", {readM, mem_err, mem_done, busy}, 4'b0110);
    check("to_ir", ir, exp_ir);
    check("to_mdr", mdr, exp_mdr);
    step();
    check("to_after", {readM, mem_err, mem_done, busy}, 4'b0000);
    mem_read = 1'b0;
    step();
`else
    // Without the timeout the block keeps waiting well past 4 cycles.
    txn(0, 1, 0, 0, 0, 8, 0, 16'h0000, 16'h0600, 16'h0000, 16'h3C3C);
`endif

    // Randomized transactions; wait latency kept under the timeout threshold.
    for (int n = 0; n < 24; n++) begin
      bit is_wr;
      is_wr = 1'($urandom);
      txn(is_wr, 1'($urandom), is_wr ? 1'b0 : 1'($urandom), 1'($urandom), 1'($urandom),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
          16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
